// File: rtl/inter_pe_req_sched_if.sv
// Bundle between the lookup/fill producers and the column-0 inter-PE request
// sequencer. The master side drives lookups and fill tags. The slave side (the
// sequencer) drives the buffer request, the hit mask and the status signals.
interface inter_pe_req_sched_if #(
    parameter int ID_W    = 4,
    parameter int PHASE_W = 2
);
    // lookup request queue input
    logic               lk_valid;
    logic               lk_ready;
    logic [ID_W-1:0]    lk_id;
    logic [ID_W-1:0]    lk_skip_id;
    logic [PHASE_W-1:0] lk_phase;

    // result pair arriving on the buffer inputs
    logic               fill_valid;
    logic [ID_W-1:0]    fill_id0;
    logic [ID_W-1:0]    fill_id1;
    logic [PHASE_W-1:0] fill_phase;

    // buffer inter-request and status
    logic               req_valid;
    logic [ID_W-1:0]    req_id;
    logic [ID_W-1:0]    req_skip_id;
    logic [PHASE_W-1:0] req_phase;
    logic [3:0]         hit_mask;
    logic               drop_pulse;
    logic [2:0]         occupancy;

    modport master (
        output lk_valid, lk_id, lk_skip_id, lk_phase,
        output fill_valid, fill_id0, fill_id1, fill_phase,
        input  lk_ready,
        input  req_valid, req_id, req_skip_id, req_phase,
        input  hit_mask, drop_pulse, occupancy
    );

    modport slave (
        input  lk_valid, lk_id, lk_skip_id, lk_phase,
        input  fill_valid, fill_id0, fill_id1, fill_phase,
        output lk_ready,
        output req_valid, req_id, req_skip_id, req_phase,
        output hit_mask, drop_pulse, occupancy
    );
endinterface

// File: rtl/inter_pe_req_sched.sv
// Sequencer for the column-0 inter-PE result buffer (4 slots, pair-wise fill).
// It queues lookups {id, skip_id, phase} and mirrors the buffer's slot tags.
// Once per cycle it either issues a lookup whose tags are present or drives a
// fill into the next slot pair. The fill pair alternates between 2/3 and 0/1.
// A head lookup that misses TIMEOUT times in a row is dropped.
module inter_pe_req_sched #(
    parameter int ID_W    = 4,
    parameter int PHASE_W = 2,
    parameter int QDEPTH  = 4,
    parameter int TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 rst,
    inter_pe_req_sched_if.slave bus
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [7:0]    TO_CNT = 8'(TIMEOUT);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ID_W-1:0]    skip_id;
        logic [PHASE_W-1:0] phase;
    } lk_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // ---------------- lookup FIFO ----------------
    lk_t           fifo_mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    lk_t           lk_in;
    lk_t           head;
    logic          lk_ready;
    logic          push;
    logic          pop;

    assign lk_in.id      = bus.lk_id;
    assign lk_in.skip_id = bus.lk_skip_id;
    assign lk_in.phase   = bus.lk_phase;
    assign head          = fifo_mem[rd_ptr];
    assign lk_ready      = (count != FULL_CNT);
    assign push          = bus.lk_valid && lk_ready;

    // next occupancy of the queue, so the FSM can pick WAIT/IDLE for next cycle
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // FIFO payload storage; the entries need no reset because count gates them
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= lk_in;
    end

    // FIFO pointers and count. Reset discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // ---------------- slot tag mirror ----------------
    logic [3:0]                     slot_v;
    logic [3:0][ID_W-1:0]           slot_id;
    logic [3:0][PHASE_W-1:0]        slot_ph;
    logic                           fill_ptr;   // 1: pair 2/3, 0: pair 0/1
    logic [1:0]                     fill_lo;
    logic [1:0]                     fill_hi;

    assign fill_lo = {fill_ptr, 1'b0};
    assign fill_hi = {fill_ptr, 1'b1};

    // Slot match for both head ids. If several slots match, the highest index
    // is the one taken, so the ascending loop lets the last match win.
    logic [3:0] id_oh;
    logic [3:0] skip_oh;
    always_comb begin
        id_oh   = '0;
        skip_oh = '0;
        for (int s = 0; s < 4; s++) begin
            if (slot_v[s] && slot_id[s] == head.id && slot_ph[s] == head.phase) begin
                id_oh    = '0;
                id_oh[s] = 1'b1;
            end
            if (slot_v[s] && slot_id[s] == head.skip_id && slot_ph[s] == head.phase) begin
                skip_oh    = '0;
                skip_oh[s] = 1'b1;
            end
        end
    end

    // valid-slot count straight from the mirror's valid bits
    logic [2:0] occ;
    always_comb begin
        occ = '0;
        for (int s = 0; s < 4; s++) occ = occ + {2'b00, slot_v[s]};
    end

    // ---------------- per-cycle decision ----------------
    state_t     state;
    logic [7:0] miss_cnt;
    logic [7:0] miss_inc;
    logic       issue;
    logic       miss;
    logic       do_fill;

    assign issue    = (state == S_WAIT) && (|id_oh || |skip_oh);
    assign miss     = (state == S_WAIT) && !issue;
    assign do_fill  = bus.fill_valid && ((state == S_IDLE) || miss);
    assign pop      = issue || (state == S_DROP);
    // saturates at TIMEOUT; the FSM leaves WAIT on reaching it anyway
    assign miss_inc = (miss_cnt == TO_CNT) ? miss_cnt : miss_cnt + 8'd1;

    logic               req_valid_q;
    logic [ID_W-1:0]    req_id_q;
    logic [ID_W-1:0]    req_skip_q;
    logic [PHASE_W-1:0] req_phase_q;
    logic [3:0]         hit_mask_q;
    logic               drop_q;

    // Sequencer FSM. It updates the registered request outputs, the tag mirror,
    // the fill pointer and the miss counter in one place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            miss_cnt    <= '0;
            fill_ptr    <= 1'b1;
            slot_v      <= '0;
            slot_id     <= '0;
            slot_ph     <= '0;
            req_valid_q <= 1'b0;
            req_id_q    <= '0;
            req_skip_q  <= '0;
            req_phase_q <= '0;
            hit_mask_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            req_valid_q <= issue;
            req_id_q    <= issue ? head.id      : '0;
            req_skip_q  <= issue ? head.skip_id : '0;
            req_phase_q <= issue ? head.phase   : '0;
            hit_mask_q  <= issue ? (id_oh | skip_oh) : 4'b0000;
            drop_q      <= (state == S_DROP);

            // A pair fill may evict valid tags. The pointer flips only on a fill.
            if (do_fill) begin
                slot_v[fill_lo]  <= 1'b1;
                slot_id[fill_lo] <= bus.fill_id0;
                slot_ph[fill_lo] <= bus.fill_phase;
                slot_v[fill_hi]  <= 1'b1;
                slot_id[fill_hi] <= bus.fill_id1;
                slot_ph[fill_hi] <= bus.fill_phase;
                fill_ptr         <= ~fill_ptr;
            end

            // On issue, the consumed slots take the incoming pair. The skip
            // assignment comes second, so it wins when both ids share a slot.
            if (issue) begin
                for (int s = 0; s < 4; s++) begin
                    if (id_oh[s]) begin
                        slot_v[s]  <= bus.fill_valid;
                        slot_id[s] <= bus.fill_id0;
                        slot_ph[s] <= bus.fill_phase;
                    end
                    if (skip_oh[s]) begin
                        slot_v[s]  <= bus.fill_valid;
                        slot_id[s] <= bus.fill_id1;
                        slot_ph[s] <= bus.fill_phase;
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    miss_cnt <= '0;
                    state    <= (count_nxt != '0) ? S_WAIT : S_IDLE;
                end
                S_WAIT: begin
                    if (issue) begin
                        miss_cnt <= '0;
                        state    <= (count_nxt != '0) ? S_WAIT : S_IDLE;
                    end else begin
                        miss_cnt <= miss_inc;
                        state    <= (miss_inc == TO_CNT) ? S_DROP : S_WAIT;
                    end
                end
                S_DROP: begin
                    miss_cnt <= '0;
                    state    <= (count_nxt != '0) ? S_WAIT : S_IDLE;
                end
                default: begin
                    miss_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.lk_ready    = lk_ready;
    assign bus.req_valid   = req_valid_q;
    assign bus.req_id      = req_id_q;
    assign bus.req_skip_id = req_skip_q;
    assign bus.req_phase   = req_phase_q;
    assign bus.hit_mask    = hit_mask_q;
    assign bus.drop_pulse  = drop_q;
    assign bus.occupancy   = occ;
endmodule

// File: tb/tb_inter_pe_req_sched.sv
// Directed bench for the inter-PE request sequencer. It covers reset, pair
// fills, hits with slot refill, multi-match, phase mismatch, timeout drop,
// a full queue and a mid-operation reset. Expected values are worked out by hand.
module tb_inter_pe_req_sched;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    inter_pe_req_sched_if #(.ID_W(4), .PHASE_W(2)) bus ();

    inter_pe_req_sched #(
        .ID_W(4), .PHASE_W(2), .QDEPTH(4), .TIMEOUT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic [3:0] skip, input logic [1:0] ph);
        bus.lk_valid   = 1'b1;
        bus.lk_id      = id;
        bus.lk_skip_id = skip;
        bus.lk_phase   = ph;
        tick();
        bus.lk_valid   = 1'b0;
    endtask

    task automatic fill(input logic [3:0] a, input logic [3:0] b, input logic [1:0] ph);
        bus.fill_valid = 1'b1;
        bus.fill_id0   = a;
        bus.fill_id1   = b;
        bus.fill_phase = ph;
        tick();
        bus.fill_valid = 1'b0;
    endtask

    // Counts cycles from the push edge to the drop pulse. It also watches for any
    // stray request, then checks that the pulse lasts exactly one cycle.
    task automatic wait_drop(input string tag, input int exp_n);
        int   n    = 0;
        logic sreq = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bus.req_valid) sreq = 1'b1;
            if (bus.drop_pulse) break;
        end
        chk({tag, "_cycles"}, n, exp_n);
        chk({tag, "_noreq"}, sreq, 1'b0);
        tick();
        chk({tag, "_pulse_end"}, bus.drop_pulse, 1'b0);
    endtask

    initial begin
        int   n;
        logic early;
        rst            = 1'b1;
        bus.lk_valid   = 1'b0;
        bus.lk_id      = '0;
        bus.lk_skip_id = '0;
        bus.lk_phase   = '0;
        bus.fill_valid = 1'b0;
        bus.fill_id0   = '0;
        bus.fill_id1   = '0;
        bus.fill_phase = '0;
        #12;
        chk("rst_req_valid", bus.req_valid, 1'b0);
        chk("rst_lk_ready",  bus.lk_ready,  1'b1);
        chk("rst_occ",       bus.occupancy, 3'd0);
        chk("rst_hit_mask",  bus.hit_mask,  4'd0);
        chk("rst_drop",      bus.drop_pulse, 1'b0);
        rst = 1'b0;
        tick();

        // pair fills: (1,2) into slots 2/3, then (3,4) into slots 0/1
        fill(4'd1, 4'd2, 2'd0);
        chk("fill1_occ", bus.occupancy, 3'd2);
        chk("fill1_req", bus.req_valid, 1'b0);
        fill(4'd3, 4'd4, 2'd0);
        chk("fill2_occ", bus.occupancy, 3'd4);
        chk("fill2_req", bus.req_valid, 1'b0);

        // hit on slots 0 (id 3) and 2 (id 1); the consumed slots take 7 and 8
        push(4'd3, 4'd1, 2'd0);
        chk("hit1_pre_req", bus.req_valid, 1'b0);
        bus.fill_valid = 1'b1;
        bus.fill_id0   = 4'd7;
        bus.fill_id1   = 4'd8;
        bus.fill_phase = 2'd0;
        tick();
        bus.fill_valid = 1'b0;
        chk("hit1_req_valid", bus.req_valid,   1'b1);
        chk("hit1_req_id",    bus.req_id,      4'd3);
        chk("hit1_req_skip",  bus.req_skip_id, 4'd1);
        chk("hit1_req_phase", bus.req_phase,   2'd0);
        chk("hit1_mask",      bus.hit_mask,    4'b0101);
        chk("hit1_occ",       bus.occupancy,   3'd4);
        chk("hit1_lk_ready",  bus.lk_ready,    1'b1);

        // the refilled tags 7/8 must now hit; no fill this time, so both slots empty
        push(4'd7, 4'd8, 2'd0);
        tick();
        chk("hit2_req_valid", bus.req_valid, 1'b1);
        chk("hit2_req_id",    bus.req_id,    4'd7);
        chk("hit2_mask",      bus.hit_mask,  4'b0101);
        chk("hit2_occ",       bus.occupancy, 3'd2);
        tick();
        chk("hit2_after_req",  bus.req_valid, 1'b0);
        chk("hit2_after_mask", bus.hit_mask,  4'd0);

        // id 5 sits in slots 2 and 3; slot 3 wins, and id==skip takes fill_id1
        fill(4'd5, 4'd5, 2'd2);
        chk("multi_fill_occ", bus.occupancy, 3'd3);
        push(4'd5, 4'd5, 2'd2);
        bus.fill_valid = 1'b1;
        bus.fill_id0   = 4'd10;
        bus.fill_id1   = 4'd11;
        bus.fill_phase = 2'd2;
        tick();
        bus.fill_valid = 1'b0;
        chk("multi_req_valid", bus.req_valid, 1'b1);
        chk("multi_mask",      bus.hit_mask,  4'b1000);
        chk("multi_occ",       bus.occupancy, 3'd3);
        // slot 3 must now hold 11; skip id 6 is absent, so only one half hits
        push(4'd11, 4'd6, 2'd2);
        tick();
        chk("half_req_valid", bus.req_valid,   1'b1);
        chk("half_req_skip",  bus.req_skip_id, 4'd6);
        chk("half_mask",      bus.hit_mask,    4'b1000);
        chk("half_occ",       bus.occupancy,   3'd2);

        // phase mismatch: slot 0 holds id 5 at phase 0, the lookup asks for phase 1
        fill(4'd5, 4'd6, 2'd0);
        chk("ph_fill_occ", bus.occupancy, 3'd3);
        push(4'd5, 4'd5, 2'd1);
        wait_drop("ph_mis", 16);

        // plain timeout: 15 misses, then the drop cycle
        push(4'd9, 4'd9, 2'd1);
        wait_drop("timeout", 16);

        // full queue: four missing lookups; a fifth waits until the head drops
        push(4'd12, 4'd12, 2'd3);
        push(4'd13, 4'd13, 2'd3);
        push(4'd14, 4'd14, 2'd3);
        push(4'd15, 4'd15, 2'd3);
        chk("full_lk_ready", bus.lk_ready, 1'b0);
        bus.lk_valid   = 1'b1;
        bus.lk_id      = 4'd1;
        bus.lk_skip_id = 4'd1;
        bus.lk_phase   = 2'd3;
        n     = 3;
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (bus.drop_pulse) break;
            if (bus.lk_ready) early = 1'b1;
        end
        chk("full_drop_cycle",  n, 16);
        chk("full_ready_early", early, 1'b0);
        chk("full_ready_drop",  bus.lk_ready, 1'b1);
        tick();
        bus.lk_valid = 1'b0;
        chk("full_fifth_in", bus.lk_ready, 1'b0);

        // asynchronous reset mid-cycle with a full queue and valid slots
        #3;
        rst = 1'b1;
        #1;
        chk("arst_lk_ready", bus.lk_ready,  1'b1);
        chk("arst_occ",      bus.occupancy, 3'd0);
        chk("arst_req",      bus.req_valid, 1'b0);
        chk("arst_drop",     bus.drop_pulse, 1'b0);
        #2;
        rst = 1'b0;
        tick();

        // queue was discarded and the pointer is back at pair 2/3
        fill(4'd1, 4'd2, 2'd0);
        push(4'd2, 4'd1, 2'd0);
        tick();
        chk("post_req_valid", bus.req_valid, 1'b1);
        chk("post_req_id",    bus.req_id,    4'd2);
        chk("post_mask",      bus.hit_mask,  4'b1100);
        chk("post_occ",       bus.occupancy, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
